// File: rtl/sobel_kenar.sv
// Streaming 3x3 Sobel edge magnitude over a raster pixel stream, using two line buffers and no frame RAM.
// Define SOBEL_THRESH_EN to binarise interior outputs against THRESH instead of saturating the magnitude.
module sobel_kenar #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int THRESH = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [7:0]  pix_i,
  input  logic        pix_valid_i,
  output logic        pix_ready_o,
  output logic [7:0]  edge_o,
  output logic        edge_valid_o,
  input  logic        edge_ready_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [16:0] pix_cnt_o
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [16:0]   NPIX      = 17'(IMG_W * IMG_H);
  localparam logic [16:0]   NPIX_M1   = 17'(IMG_W * IMG_H - 1);
  localparam logic [16:0]   FIRST_OUT = 17'(IMG_W + 1);
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [11:0]   THR       = 12'(THRESH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [16:0]   cnt_q, cnt_d;
  logic [16:0]   m_q, m_d;
  logic [CW-1:0] in_c_q, in_c_d;
  logic [CW-1:0] out_c_q, out_c_d;
  logic [RW-1:0] out_r_q, out_r_d;
  logic [7:0]    edge_q, edge_d;
  logic          edge_vld_q, edge_vld_d;
  logic [7:0]    win_q [3][3];
  logic [7:0]    win_d [3][3];
  logic [7:0]    lb0_q [IMG_W];
  logic [7:0]    lb1_q [IMG_W];

  logic               in_acc, out_acc, out_free, produce, border;
  logic signed [10:0] gx, gy;
  logic [10:0]        ax, ay;
  logic [11:0]        mag;
  logic [7:0]         edge_val;

  function automatic logic signed [10:0] wsum(input logic [7:0] a, input logic [7:0] b,
                                              input logic [7:0] c);
    return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction

  assign pix_ready_o  = (state_q == S_RUN) && (!edge_vld_q || edge_ready_i);
  assign in_acc       = pix_valid_i && pix_ready_o;
  assign out_acc      = edge_vld_q && edge_ready_i;
  assign out_free     = !edge_vld_q || edge_ready_i;
  assign produce      = (in_acc && (cnt_q >= FIRST_OUT)) ||
                        ((state_q == S_FLUSH) && (m_q != NPIX) && out_free);
  assign border       = (out_r_q == '0) || (out_r_q == ROW_LAST) ||
                        (out_c_q == '0) || (out_c_q == COL_LAST);

  assign edge_o       = edge_q;
  assign edge_valid_o = edge_vld_q;
  assign busy_o       = (state_q == S_RUN) || (state_q == S_FLUSH);
  assign done_o       = (state_q == S_DONE);
  assign pix_cnt_o    = cnt_q;

  // Window columns shift left; the new right column is {row r-2, row r-1, incoming row}.
  always_comb begin
    win_d = win_q;
    if (in_acc) begin
      for (int i = 0; i < 3; i++) begin
        win_d[i][0] = win_q[i][1];
        win_d[i][1] = win_q[i][2];
      end
      win_d[0][2] = lb0_q[in_c_q];
      win_d[1][2] = lb1_q[in_c_q];
      win_d[2][2] = pix_i;
    end
  end

  always_comb begin
    gx  = wsum(win_d[0][2], win_d[1][2], win_d[2][2]) - wsum(win_d[0][0], win_d[1][0], win_d[2][0]);
    gy  = wsum(win_d[2][0], win_d[2][1], win_d[2][2]) - wsum(win_d[0][0], win_d[0][1], win_d[0][2]);
    ax  = gx[10] ? 11'(-gx) : 11'(gx);
    ay  = gy[10] ? 11'(-gy) : 11'(gy);
    mag = 12'(ax) + 12'(ay);
`ifdef SOBEL_THRESH_EN
    edge_val = border ? 8'h00 : ((mag >= THR) ? 8'hFF : 8'h00);
`else
    edge_val = border ? 8'h00 : ((mag > 12'd255) ? 8'hFF : mag[7:0]);
`endif
  end

`ifndef SOBEL_THRESH_EN
  logic unused_thr;
  assign unused_thr = ^THR;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_d        = m_q;
    in_c_d     = in_c_q;
    out_c_d    = out_c_q;
    out_r_d    = out_r_q;
    edge_d     = edge_q;
    edge_vld_d = edge_vld_q;

    if (produce) begin
      edge_d     = edge_val;
      edge_vld_d = 1'b1;
      m_d        = m_q + 17'd1;
      if (out_c_q == COL_LAST) begin
        out_c_d = '0;
        out_r_d = out_r_q + 1'b1;
      end else begin
        out_c_d = out_c_q + 1'b1;
      end
    end else if (out_acc) begin
      edge_vld_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          cnt_d   = '0;
          m_d     = '0;
          in_c_d  = '0;
          out_c_d = '0;
          out_r_d = '0;
        end
      end
      S_RUN: begin
        if (in_acc) begin
          cnt_d  = cnt_q + 17'd1;
          in_c_d = (in_c_q == COL_LAST) ? '0 : in_c_q + 1'b1;
          if (cnt_q == NPIX_M1) state_d = S_FLUSH;
        end
      end
      // With all outputs produced, the held register is the last one.
      S_FLUSH: begin
        if (out_acc && (m_q == NPIX)) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      m_q        <= '0;
      in_c_q     <= '0;
      out_c_q    <= '0;
      out_r_q    <= '0;
      edge_q     <= '0;
      edge_vld_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          win_q[i][j] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      m_q        <= m_d;
      in_c_q     <= in_c_d;
      out_c_q    <= out_c_d;
      out_r_q    <= out_r_d;
      edge_q     <= edge_d;
      edge_vld_q <= edge_vld_d;
      win_q      <= win_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
    end else if (in_acc) begin
      lb0_q[in_c_q] <= lb1_q[in_c_q];
      lb1_q[in_c_q] <= pix_i;
    end
  end
endmodule

// File: doc/sobel_kenar.md
Name: sobel_kenar

Overview:
- Streaming 3x3 Sobel edge-magnitude stage, directly downstream of the median-filter stage.
- Consumes the median-filtered 320x240 8-bit image as a raster-order pixel stream and emits one saturated gradient magnitude per input pixel, in the same raster order.
- Two internal line buffers; no frame RAM.
- Valid/ready handshake on both sides, so the upstream RAM read-out loop and any downstream sink can stall freely.

Parameters:
- IMG_W, 320, pixels per row (>=3)
- IMG_H, 240, rows per frame (>=3)
- THRESH, 64, binarisation threshold; used only when SOBEL_THRESH_EN is defined

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  frame start request; sampled in IDLE only
- pix_i  in  8  input pixel (median output)
- pix_valid_i  in  1  pix_i valid
- pix_ready_o  out  1  block accepts pix_i this cycle
- edge_o  out  8  output magnitude
- edge_valid_o  out  1  edge_o valid
- edge_ready_i  in  1  sink accepts edge_o
- busy_o  out  1  high in RUN or FLUSH
- done_o  out  1  one-cycle pulse when last output accepted
- pix_cnt_o  out  17  number of input pixels accepted this frame

Behaviour:
- Reset (rst_i=0, async): all outputs 0; state IDLE; counters and line buffers cleared. Reset mid-frame discards the frame; no done_o.
- Transfer occurs on a clock edge with valid&ready high; input and output sides are independent.
- FSM:
  - IDLE: start_i=1 -> RUN; input index k, output index m and pix_cnt_o cleared.
  - RUN: pix_ready_o = !edge_valid_o || edge_ready_i, i.e. a single-entry output register with bypass on accept. Each accepted input increments k.
  - RUN -> FLUSH: after input k = IMG_W*IMG_H-1 is accepted; pix_ready_o=0 from then on.
  - FLUSH: emits the remaining IMG_W+1 outputs without input, honouring edge_ready_i.
  - FLUSH -> DONE: after output m = IMG_W*IMG_H-1 is accepted.
  - DONE: done_o=1 for one cycle -> IDLE.
- start_i is ignored outside IDLE.
- Output timing:
  - Output m (pixel r=m/IMG_W, c=m%IMG_W) is produced when input k = m+IMG_W+1 is accepted.
  - It is registered and edge_valid_o rises on the next edge (latency 1 cycle after that input).
  - Inputs k < IMG_W+1 produce no output.
- Border: r=0, r=IMG_H-1, c=0 or c=IMG_W-1 -> edge_o=0. All FLUSH outputs are border pixels, so they are 0.
- Interior window p[i][j], with i=row offset -1..+1 and j=col offset -1..+1 mapped to 0..2:
  - Gx = (p02+2p12+p22) - (p00+2p10+p20)
  - Gy = (p20+2p21+p22) - (p00+2p01+p02)
  - Gx and Gy are 11-bit signed.
  - mag = |Gx|+|Gy|, 12-bit unsigned; edge_o = (mag>255) ? 255 : mag.
- Line buffers: two IMG_W x 8 arrays plus a 3x3 register window. Column index wraps IMG_W-1 -> 0 on row change. Window contents from the previous row never leak across the row boundary; this is guaranteed by the border rule.
- Stall: while edge_valid_o=1 and edge_ready_i=0, edge_o and edge_valid_o hold, and no input is accepted.
- pix_valid_i=0 in RUN: no state change; edge_valid_o drops after the pending output is accepted.
- pix_cnt_o saturates at IMG_W*IMG_H and holds until the next start_i.

Optional Feature:
- SOBEL_THRESH_EN defined: interior edge_o = (mag >= THRESH) ? 255 : 0; border still 0; latency unchanged.
- Undefined: saturated magnitude as above; THRESH is unused.

Test Plan:
- Flat frame, all pixels 100, edge_ready_i=1 -> exactly 76800 outputs, all 0; one done_o pulse; pix_cnt_o=76800; back in IDLE.
- Vertical step, pixel=0 for c<160 and 200 for c>=160 -> interior rows: edge_o=255 at c=159 and c=160 (mag 800 saturated), 0 elsewhere; border 0.
- Row ramp, pixel=r -> every interior output = 8 (Gy=8, Gx=0); border 0.
- Backpressure: edge_ready_i pseudo-random 50%, pix_valid_i pseudo-random 70%, step image -> output sequence identical to the unstalled run; no drops or duplicates; pix_ready_o=0 whenever edge_valid_o&!edge_ready_i.
- Reset mid-frame: rst_i low for 2 cycles after 1000 inputs -> all outputs 0 immediately, no done_o; a new start_i plus full flat frame -> 76800 zeros and done_o.
- SOBEL_THRESH_EN, THRESH=64 -> row ramp gives all 0; vertical step gives 255 at c=159/160, 0 elsewhere.
